// File: rtl/hazard_forwarding_unit.sv
// ID-stage hazard unit: operand forwarding selects, load-use stall
// control and a saturating stall-cycle counter.
module hazard_forwarding_unit #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic             ID_use_rs2,
    input  logic             ID_store_instr,
    input  logic [4:0]       EX_rd,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic [1:0]       fwd_rd,
    output logic             S,
    output logic             LE_pc,
    output logic             LE_npc,
    output logic             LE_ifid,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    localparam logic [2:0] LP_REM_INIT = 3'(STALL_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_rem;
    logic [2:0]       w_rem_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu;
    logic             w_bubble;
    logic             w_ex_rs1;
    logic             w_ex_rs2;
    logic             w_ex_rd;

    // Youngest producing stage wins; x0 is hard-wired and never forwarded.
    function automatic logic [1:0] f_sel(
        input logic [4:0] src,
        input logic [4:0] ex_rd,
        input logic       ex_en,
        input logic [4:0] mem_rd,
        input logic       mem_en,
        input logic [4:0] wb_rd,
        input logic       wb_en
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if (ex_en && ex_rd == src) begin
                sel = 2'b01;
            end else if (mem_en && mem_rd == src) begin
                sel = 2'b10;
            end else if (wb_en && wb_rd == src) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_rs1 = f_sel(ID_rs1, EX_rd, EX_RF_enable, MEM_rd,
                        MEM_RF_enable, WB_rd, WB_RF_enable);
        fwd_rs2 = 2'b00;
        fwd_rd  = 2'b00;
        if (ID_use_rs2) begin
            fwd_rs2 = f_sel(ID_rs2, EX_rd, EX_RF_enable, MEM_rd,
                            MEM_RF_enable, WB_rd, WB_RF_enable);
        end
        if (ID_store_instr) begin
            fwd_rd = f_sel(ID_rd, EX_rd, EX_RF_enable, MEM_rd,
                           MEM_RF_enable, WB_rd, WB_RF_enable);
        end
    end

    assign w_ex_rs1 = (EX_rd == ID_rs1);
    assign w_ex_rs2 = ID_use_rs2 & (EX_rd == ID_rs2);
    assign w_ex_rd  = ID_store_instr & (EX_rd == ID_rd);

    assign w_lu = EX_load_instr & EX_RF_enable & (EX_rd != 5'd0)
                & (w_ex_rs1 | w_ex_rs2 | w_ex_rd);

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_state <= RUN;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Mealy in RUN; in STALL the held instruction sits behind a bubble,
    // so lu is ignored until the stall has run its full length.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_bubble    = 1'b0;
        case (r_state)
            RUN: begin
                if (w_lu) begin
                    w_bubble = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        w_state_nxt = STALL;
                        w_rem_nxt   = LP_REM_INIT;
                    end
                end
            end
            STALL: begin
                w_bubble = 1'b1;
                if (r_rem <= 3'd1) begin
                    w_state_nxt = RUN;
                    w_rem_nxt   = 3'd0;
                end else begin
                    w_rem_nxt = r_rem - 3'd1;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_rem_nxt   = 3'd0;
            end
        endcase
    end

    assign S       = w_bubble;
    assign LE_pc   = ~w_bubble;
    assign LE_npc  = ~w_bubble;
    assign LE_ifid = ~w_bubble;

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            r_cnt <= '0;
        end else if (w_bubble && r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Scoreboard bench: two units (1-cycle and 3-cycle stall) share stimulus
// and are checked against a cycle-level reference model.
module tb_hazard_forwarding_unit;

    logic       Clk;
    logic       R;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic       ID_use_rs2, ID_store_instr;
    logic [4:0] EX_rd, MEM_rd, WB_rd;
    logic       EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic       EX_load_instr;

    logic [1:0]  f1_rs1, f1_rs2, f1_rd, f3_rs1, f3_rs2, f3_rd;
    logic        S1, pc1, npc1, ifid1, S3, pc3, npc3, ifid3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    hazard_forwarding_unit #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
        .Clk(Clk), .R(R),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_use_rs2(ID_use_rs2), .ID_store_instr(ID_store_instr),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable),
        .WB_RF_enable(WB_RF_enable), .EX_load_instr(EX_load_instr),
        .fwd_rs1(f1_rs1), .fwd_rs2(f1_rs2), .fwd_rd(f1_rd),
        .S(S1), .LE_pc(pc1), .LE_npc(npc1), .LE_ifid(ifid1),
        .stall_count(cnt1)
    );

    hazard_forwarding_unit #(.STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .Clk(Clk), .R(R),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_use_rs2(ID_use_rs2), .ID_store_instr(ID_store_instr),
        .EX_rd(EX_rd), .MEM_rd(MEM_rd), .WB_rd(WB_rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable),
        .WB_RF_enable(WB_RF_enable), .EX_load_instr(EX_load_instr),
        .fwd_rs1(f3_rs1), .fwd_rs2(f3_rs2), .fwd_rd(f3_rd),
        .S(S3), .LE_pc(pc3), .LE_npc(npc3), .LE_ifid(ifid3),
        .stall_count(cnt3)
    );

    typedef struct {
        int f_rs1, f_rs2, f_rd;
        int s1, s3;
        int c1, c3;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    int   busy1 = 0, busy3 = 0;
    int   mc1 = 0, mc3 = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_sel(input logic [4:0] src);
        if (src == 5'd0) return 0;
        if (EX_RF_enable && EX_rd == src) return 1;
        if (MEM_RF_enable && MEM_rd == src) return 2;
        if (WB_RF_enable && WB_rd == src) return 3;
        return 0;
    endfunction

    function automatic bit ref_lu();
        bit hit;
        hit = (EX_rd == ID_rs1)
           || (ID_use_rs2 && EX_rd == ID_rs2)
           || (ID_store_instr && EX_rd == ID_rd);
        return EX_load_instr && EX_RF_enable && EX_rd != 5'd0 && hit;
    endfunction

    // Cycle model: a hazard owns the next n cycles of bubbles.
    task automatic advance(input int n, input int s, input int cmax,
                           inout int busy, inout int cnt);
        if (busy > 0) busy--;
        else if (s != 0) busy = n - 1;
        if (s != 0 && cnt < cmax) cnt++;
    endtask

    task automatic issue();
        exp_t e;
        bit   lu;
        lu = ref_lu();
        if (!R) begin
            busy1 = 0; busy3 = 0; mc1 = 0; mc3 = 0;
        end
        e.f_rs1 = ref_sel(ID_rs1);
        e.f_rs2 = ID_use_rs2 ? ref_sel(ID_rs2) : 0;
        e.f_rd  = ID_store_instr ? ref_sel(ID_rd) : 0;
        e.s1 = (busy1 > 0 || lu) ? 1 : 0;
        e.s3 = (busy3 > 0 || lu) ? 1 : 0;
        e.c1 = mc1;
        e.c3 = mc3;
        q.push_back(e);
        if (R) begin
            advance(1, e.s1, 65535, busy1, mc1);
            advance(3, e.s3, 15, busy3, mc3);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
        ID_use_rs2 = 0; ID_store_instr = 0;
        EX_rd = 0; MEM_rd = 0; WB_rd = 0;
        EX_RF_enable = 0; MEM_RF_enable = 0; WB_RF_enable = 0;
        EX_load_instr = 0;
    endtask

    task automatic hazard3();
        idle();
        EX_load_instr = 1; EX_rd = 3; EX_RF_enable = 1; ID_rs1 = 3;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fwd_rs1_u1", int'(f1_rs1), e.f_rs1);
                chk("fwd_rs2_u1", int'(f1_rs2), e.f_rs2);
                chk("fwd_rd_u1",  int'(f1_rd),  e.f_rd);
                chk("fwd_rs1_u3", int'(f3_rs1), e.f_rs1);
                chk("fwd_rs2_u3", int'(f3_rs2), e.f_rs2);
                chk("fwd_rd_u3",  int'(f3_rd),  e.f_rd);
                chk("S_u1", int'(S1), e.s1);
                chk("S_u3", int'(S3), e.s3);
                chk("LE_u1", int'({pc1, npc1, ifid1}), e.s1 ? 0 : 7);
                chk("LE_u3", int'({pc3, npc3, ifid3}), e.s3 ? 0 : 7);
                chk("stall_count_u1", int'(cnt1), e.c1);
                chk("stall_count_u3", int'(cnt3), e.c3);
            end
        end
    end

    initial begin
        int waited;
        R = 1'b0;
        idle();
        @(posedge Clk);
        #1;
        issue();
        issue();
        R = 1'b1;
        EX_rd = 5; EX_RF_enable = 1; ID_rs1 = 5;
        issue();
        idle();
        ID_rs2 = 7; ID_use_rs2 = 1;
        MEM_rd = 7; WB_rd = 7; MEM_RF_enable = 1; WB_RF_enable = 1;
        issue();
        ID_use_rs2 = 0;
        issue();
        idle();
        EX_RF_enable = 1; MEM_RF_enable = 1; WB_RF_enable = 1;
        EX_load_instr = 1; ID_store_instr = 1; ID_use_rs2 = 1;
        issue();
        hazard3();
        issue();
        idle();
        MEM_rd = 3; MEM_RF_enable = 1; ID_rs1 = 3;
        issue();
        issue();
        idle();
        issue();
        R = 1'b0;
        issue();
        R = 1'b1;
        hazard3();
        for (int i = 0; i < 6; i++) issue();
        idle();
        issue();
        hazard3();
        issue();
        idle();
        R = 1'b0;
        issue();
        R = 1'b1;
        issue();
        for (int i = 0; i < 500; i++) begin
            ID_rs1 = 5'($urandom_range(0, 3));
            ID_rs2 = 5'($urandom_range(0, 3));
            ID_rd  = 5'($urandom_range(0, 3));
            ID_use_rs2     = 1'($urandom_range(0, 1));
            ID_store_instr = 1'($urandom_range(0, 1));
            EX_rd  = 5'($urandom_range(0, 3));
            MEM_rd = 5'($urandom_range(0, 3));
            WB_rd  = 5'($urandom_range(0, 3));
            EX_RF_enable  = 1'($urandom_range(0, 1));
            MEM_RF_enable = 1'($urandom_range(0, 1));
            WB_RF_enable  = 1'($urandom_range(0, 1));
            EX_load_instr = ($urandom_range(0, 3) == 0);
            R = ($urandom_range(0, 59) != 0);
            issue();
        end
        waited = 0;
        while (q.size() > 0 && waited < 5) begin
            @(negedge Clk);
            #1;
            waited++;
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
